multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Parametrised FSM control unit for the multi-cycle RV32I datapath; successor to the single-cycle main decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives per-state datapath selects and gates PC/IR/register/memory writes, stalling on a memory ready handshake. Sits between the instruction register (opcode) and the shared ALU/memory/register-file datapath.

Parameters:
OPCODE_W, 7, opcode field width
ALUOP_W, 2, width of ALUOp to the ALU decoder
EN_ITYPE, 1, 1 = support OP-IMM (0010011); 0 = treat as illegal
EN_JAL, 1, 1 = support JAL (1101111); 0 = treat as illegal

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
opcode  in  OPCODE_W  IR[6:0], stable from the cycle after FETCH completes
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
MemWrite  out  1  memory write strobe
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
IRWrite  out  1  load IR and OldPC
PCWrite  out  1  load PC
RegWrite  out  1  register-file write
ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ALUOp  out  ALUOP_W  00 add, 01 sub/branch, 10 funct-decoded
illegal  out  1  one-cycle pulse on an unsupported opcode
state_dbg  out  4  current state encoding

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high. While reset=1, every output is 0 and state is loaded with FETCH. The first cycle after reset is FETCH.
- Outputs are Moore decodes of state. The only exceptions are PCWrite/IRWrite, which are gated by mem_ready or zero as described below.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10. Codes 11-15 are unreachable and go to FETCH.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI (only if EN_ITYPE)
  - 1100011 -> BRANCH
  - 1101111 -> JAL (only if EN_JAL)
  - any other opcode -> FETCH, with illegal=1 for this cycle only. No register or memory write occurs.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Hold while mem_ready=0; go to MEMWB on mem_ready=1.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: mem_req=1, MemWrite=1, AdrSrc=1. Hold while mem_ready=0; go to FETCH on mem_ready=1. MemWrite stays high for every stalled cycle.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=zero. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 -> ALUWB (writes rd = OldPC+4).
- Latency in cycles with mem_ready tied high: R/I-type 4, load 5, store 4, branch 3, JAL 4. Each stall cycle adds 1.
- Signals not listed for a state are 0.
- A mid-instruction reset (including during a memory stall) aborts the instruction with no write strobe in the reset cycle.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit, codes above);
  - opcode localparams OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL;
  - the select encodings for ResultSrc, ALUSrcA and ALUSrcB;
  - a packed control-word struct.
- One combinational sub-module, mc_ctrl_rom, maps state to the control word. The top holds the state register, next-state logic, and the mem_ready/zero gating.

Test Plan:
- Reset held 2 cycles, then released with mem_ready=1 -> all outputs 0 during reset; then FETCH with IRWrite=1, PCWrite=1, state_dbg=0.
- opcode=0110011, mem_ready=1 -> states 0,1,6,8,0. RegWrite=1 only in cycle 4; ALUOp=10 in cycle 3.
- Load (0000011) with mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. mem_req=1 and AdrSrc=1 through all three MEMREAD cycles; RegWrite with ResultSrc=01 once.
- Store (0100011) with a 1-cycle stall -> MemWrite=1 for 2 cycles. RegWrite stays 0 throughout.
- Branch (1100011), once with zero=1 and once with zero=0 -> PCWrite in BRANCH is 1 and 0 respectively. Each instruction is 3 cycles.
- opcode=0010011 with EN_ITYPE=0, then opcode=1111111 -> illegal pulses for 1 cycle in DECODE each time and the FSM returns to FETCH. Separately, reset asserted in MEMWRITE mid-stall -> MemWrite=0 in the reset cycle, then FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle RV32I control unit: FSM states, opcodes,
// datapath select encodings and the per-state control word.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_e;

  // pc_on_zero and ready_gated mark the strobes the top qualifies with zero / mem_ready.
  typedef struct packed {
    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        pc_on_zero;
    logic        ready_gated;
    logic        reg_write;
    result_src_e result_src;
    alu_src_a_e  alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
  } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational state-to-control-word table; pure Moore decode, no gating.
module mc_ctrl_rom
  import mc_ctrl_pkg::*;
(
  input  state_e     state_i,
  output ctrl_word_t cw_o
);

  always_comb begin
    // NOTE: default every field first so no path through the case infers a latch.
    cw_o = '0;
    case (state_i)
      S_FETCH: begin
        cw_o.mem_req     = 1'b1;
        cw_o.ir_write    = 1'b1;
        cw_o.pc_write    = 1'b1;
        cw_o.ready_gated = 1'b1;
        cw_o.result_src  = RES_ALURESULT;
        cw_o.alu_src_a   = SRCA_PC;
        cw_o.alu_src_b   = SRCB_FOUR;
        cw_o.alu_op      = ALUOP_ADD;
      end
      S_DECODE: begin
        cw_o.alu_src_a = SRCA_OLDPC;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        cw_o.alu_src_a = SRCA_RD1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        cw_o.mem_req    = 1'b1;
        cw_o.adr_src    = 1'b1;
        cw_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        cw_o.result_src = RES_DATA;
        cw_o.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        cw_o.mem_req   = 1'b1;
        cw_o.mem_write = 1'b1;
        cw_o.adr_src   = 1'b1;
      end
      S_EXECR: begin
        cw_o.alu_src_a = SRCA_RD1;
        cw_o.alu_src_b = SRCB_RD2;
        cw_o.alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        cw_o.alu_src_a = SRCA_RD1;
        cw_o.alu_src_b = SRCB_IMM;
        cw_o.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw_o.result_src = RES_ALUOUT;
        cw_o.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        cw_o.pc_on_zero = 1'b1;
        cw_o.result_src = RES_ALUOUT;
        cw_o.alu_src_a  = SRCA_RD1;
        cw_o.alu_src_b  = SRCB_RD2;
        cw_o.alu_op     = ALUOP_SUB;
      end
      S_JAL: begin
        cw_o.pc_write   = 1'b1;
        cw_o.result_src = RES_ALUOUT;
        cw_o.alu_src_a  = SRCA_OLDPC;
        cw_o.alu_src_b  = SRCB_FOUR;
        cw_o.alu_op     = ALUOP_ADD;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: state register, opcode-driven sequencing and
// mem_ready/zero qualification of the PC and IR write strobes.
module multicycle_control #(
  parameter int OPCODE_W = 7,
  parameter int ALUOP_W  = 2,
  parameter bit EN_ITYPE = 1'b1,
  parameter bit EN_JAL   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MemWrite,
  output logic                AdrSrc,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                illegal,
  output logic [3:0]          state_dbg
);

  import mc_ctrl_pkg::*;

  state_e     state_q, state_d;
  ctrl_word_t cw;
  logic       bad_opcode;

  logic is_load, is_store, is_rtype, is_itype, is_branch, is_jal;
  assign is_load   = (opcode == OPCODE_W'(OP_LOAD));
  assign is_store  = (opcode == OPCODE_W'(OP_STORE));
  assign is_rtype  = (opcode == OPCODE_W'(OP_RTYPE));
  assign is_itype  = (opcode == OPCODE_W'(OP_ITYPE)) && EN_ITYPE;
  assign is_branch = (opcode == OPCODE_W'(OP_BRANCH));
  assign is_jal    = (opcode == OPCODE_W'(OP_JAL)) && EN_JAL;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    bad_opcode = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_load || is_store) state_d = S_MEMADR;
        else if (is_rtype)       state_d = S_EXECR;
        else if (is_itype)       state_d = S_EXECI;
        else if (is_branch)      state_d = S_BRANCH;
        else if (is_jal)         state_d = S_JAL;
        else begin
          state_d    = S_FETCH;
          bad_opcode = 1'b1;
        end
      end
      S_MEMADR:   state_d = is_load ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_rom u_rom (
    .state_i (state_q),
    .cw_o    (cw)
  );

  // Reset forces every output low so an aborted access never strobes a write.
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = '0;
    illegal   = 1'b0;
    state_dbg = 4'd0;
    if (!reset) begin
      mem_req   = cw.mem_req;
      MemWrite  = cw.mem_write;
      AdrSrc    = cw.adr_src;
      IRWrite   = cw.ir_write & mem_ready;
      PCWrite   = (cw.pc_write & (~cw.ready_gated | mem_ready)) | (cw.pc_on_zero & zero);
      RegWrite  = cw.reg_write;
      ResultSrc = cw.result_src;
      ALUSrcA   = cw.alu_src_a;
      ALUSrcB   = cw.alu_src_b;
      ALUOp     = ALUOP_W'(cw.alu_op);
      illegal   = bad_opcode;
      state_dbg = state_q;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each scenario queues per-cycle stimulus
// with the expected output vector, then drains the queue comparing at negedge.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'b0110011;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state_dbg;

  always #5 clk = ~clk;

  multicycle_control #(
    .OPCODE_W (7),
    .ALUOP_W  (2),
    .EN_ITYPE (1'b0),
    .EN_JAL   (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .zero      (zero),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .illegal   (illegal),
    .state_dbg (state_dbg)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] res, srca, srcb, aluop;
    logic       illegal;
  } obs_t;

  typedef struct packed {
    logic rst, mr, z;
  } stim_t;

  obs_t  obs;
  assign obs = {state_dbg, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal};

  obs_t  exp_q[$];
  stim_t stim_q[$];
  int    checks = 0;
  int    failures = 0;

  // Expected Moore outputs per state; mem_ready/zero-qualified strobes are added by the tests.
  function automatic obs_t ex(input int st);
    obs_t e = '0;
    e.st = 4'(st);
    case (st)
      0:  begin e.mem_req = 1; e.res = 2'b10; e.srcb = 2'b10; end
      1:  begin e.srca = 2'b01; e.srcb = 2'b01; end
      2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
      3:  begin e.mem_req = 1; e.adr_src = 1; end
      4:  begin e.res = 2'b01; e.reg_write = 1; end
      5:  begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
      6:  begin e.srca = 2'b10; e.aluop = 2'b10; end
      7:  begin e.srca = 2'b10; e.srcb = 2'b01; e.aluop = 2'b10; end
      8:  begin e.reg_write = 1; end
      9:  begin e.srca = 2'b10; e.aluop = 2'b01; end
      10: begin e.srca = 2'b01; e.srcb = 2'b10; e.pc_write = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic obs_t fetch_go();
    obs_t e = ex(0);
    e.ir_write = 1;
    e.pc_write = 1;
    return e;
  endfunction

  task automatic push(input logic rst, input logic mr, input logic z, input obs_t e);
    stim_q.push_back('{rst: rst, mr: mr, z: z});
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    reset     = s.rst;
    mem_ready = s.mr;
    zero      = s.z;
  endtask

  task automatic test_reset();
    obs_t e;
    int   cyc = 0;
    opcode = 7'b0110011;
    push(1, 1, 1, '0);
    push(1, 1, 1, '0);
    push(0, 1, 0, fetch_go());
    push(0, 1, 0, ex(1));
    push(0, 1, 0, ex(6));
    push(0, 1, 0, ex(8));
    push(0, 0, 0, ex(0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", cyc, obs.st, obs, e.st, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int   cyc = 0;
    opcode = 7'b0110011;
    for (int i = 0; i < 2; i++) begin
      push(0, 1, 0, fetch_go());
      push(0, 0, 1, ex(1));
      push(0, 0, 1, ex(6));
      push(0, 0, 0, ex(8));
    end
    push(0, 0, 0, ex(0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rtype_b2b cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", cyc, obs.st, obs, e.st, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_stall();
    obs_t e;
    int   cyc = 0;
    opcode = 7'b0000011;
    push(0, 0, 0, ex(0));
    push(0, 1, 0, fetch_go());
    push(0, 1, 0, ex(1));
    push(0, 1, 0, ex(2));
    push(0, 0, 0, ex(3));
    push(0, 0, 0, ex(3));
    push(0, 1, 0, ex(3));
    push(0, 0, 0, ex(4));
    push(0, 0, 0, ex(0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL load cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", cyc, obs.st, obs, e.st, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_stall();
    obs_t e;
    int   cyc = 0;
    opcode = 7'b0100011;
    push(0, 1, 0, fetch_go());
    push(0, 0, 0, ex(1));
    push(0, 0, 0, ex(2));
    push(0, 0, 0, ex(5));
    push(0, 1, 0, ex(5));
    push(0, 0, 0, ex(0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL store cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", cyc, obs.st, obs, e.st, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    obs_t e, taken;
    int   cyc = 0;
    opcode = 7'b1100011;
    taken = ex(9);
    taken.pc_write = 1;
    push(0, 1, 1, fetch_go());
    push(0, 1, 1, ex(1));
    push(0, 1, 1, taken);
    push(0, 1, 0, fetch_go());
    push(0, 1, 0, ex(1));
    push(0, 1, 0, ex(9));
    push(0, 0, 1, ex(0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL branch cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", cyc, obs.st, obs, e.st, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal();
    obs_t e;
    int   cyc = 0;
    opcode = 7'b1101111;
    push(0, 1, 0, fetch_go());
    push(0, 0, 0, ex(1));
    push(0, 0, 0, ex(10));
    push(0, 0, 0, ex(8));
    push(0, 0, 0, ex(0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL jal cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", cyc, obs.st, obs, e.st, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    obs_t e, bad;
    int   cyc = 0;
    logic [6:0] ops [2] = '{7'b0010011, 7'b1111111};
    bad = ex(1);
    bad.illegal = 1;
    foreach (ops[k]) begin
      opcode = ops[k];
      push(0, 1, 0, fetch_go());
      push(0, 1, 0, bad);
      push(0, 0, 0, ex(0));
      while (stim_q.size() > 0) begin
        apply(stim_q.pop_front());
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
          failures++;
          $display("FAIL illegal op=%b cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", ops[k], cyc, obs.st, obs, e.st, e);
        end
        cyc++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    int   cyc = 0;
    opcode = 7'b0100011;
    push(0, 1, 0, fetch_go());
    push(0, 1, 0, ex(1));
    push(0, 1, 0, ex(2));
    push(0, 0, 0, ex(5));
    push(1, 0, 0, '0);
    push(0, 0, 0, ex(0));
    push(0, 1, 0, fetch_go());
    push(0, 0, 0, ex(1));
    push(0, 0, 0, ex(2));
    push(0, 1, 0, ex(5));
    push(0, 0, 0, ex(0));
    while (stim_q.size() > 0) begin
      apply(stim_q.pop_front());
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL mid_reset cyc%0d: got st=%0d vec=%h expected st=%0d vec=%h", cyc, obs.st, obs, e.st, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_load_stall();
    test_store_stall();
    test_branch();
    test_jal();
    test_illegal();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
